w5300_reg_access: RTL and testbench
===================================

Name: w5300_reg_access

Overview:
- Parametrised W5300 direct-mode, 16-bit host bus master.
- Serialises single register read/write requests from the control FSMs onto the W5300 pins with programmable setup, strobe, hold and turnaround timing.
- Computes socket register addresses for a configurable socket count.
- Sits between the W5300 init/socket controllers and the chip pins.

Parameters:
- ADDR_W, 10, W5300 address bus width; must be >= 10.
- DATA_W, 16, data bus width; only 16 is supported.
- SOCKET_NUM, 8, number of addressable sockets, range 1..8.
- SETUP_CYC, 1, cycles with CS low before the strobe; >= 1.
- STROBE_CYC, 3, cycles RD/WE are held low; >= 1.
- HOLD_CYC, 1, cycles with CS low after the strobe; >= 1.
- TURN_CYC, 1, bus-idle cycles after CS rises before the response; >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept
- req_write  in  1  1 = write, 0 = read
- req_common  in  1  1 = common register, 0 = socket register
- req_socket  in  3  socket index
- req_offset  in  ADDR_W  common address, or offset inside the 0x40 socket window
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  request rejected; valid with rsp_valid
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid
- w_cs_n  out  1  chip select
- w_rd_n  out  1  read strobe
- w_we_n  out  1  write strobe
- w_addr  out  ADDR_W  chip address
- w_data_o  out  DATA_W  write data to the pad
- w_data_oe  out  1  pad output enable
- w_data_i  in  DATA_W  read data from the pad

Behaviour:
- Clock and reset are fixed: one clock `clk`; `rst` is synchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, w_cs_n=1, w_rd_n=1, w_we_n=1, w_addr=0, w_data_o=0, w_data_oe=0.
- Handshake:
  - A request is accepted on a clock edge where req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - Request fields are captured at acceptance; later input changes are ignored.
- Address computation, performed at acceptance:
  - Common: addr = req_offset. Error if req_offset >= 0x200.
  - Socket: addr = 0x200 + req_socket*0x40 + req_offset[5:0]. Error if req_socket >= SOCKET_NUM or req_offset >= 0x40.
  - Bit 0 of the computed address is forced to 0.
- States: IDLE, SETUP, STROBE, HOLD, TURN, RESP. A single down-counter is reloaded on every state entry.
  - IDLE: if accepted with error, go to RESP with rsp_err=1 and no pin activity. If accepted without error, go to SETUP.
  - SETUP (SETUP_CYC cycles): w_cs_n=0, w_addr driven. For a write, w_data_o=wdata and w_data_oe=1.
  - STROBE (STROBE_CYC cycles): w_rd_n=0 for a read, or w_we_n=0 for a write.
    - For a read, w_data_i is registered on the edge that leaves STROBE.
  - HOLD (HOLD_CYC cycles): strobes high, w_cs_n=0, address and write data still driven.
  - TURN (TURN_CYC cycles): w_cs_n=1 and w_data_oe=0.
  - RESP (1 cycle): rsp_valid=1, then IDLE.
- Latency: rsp_valid is high in cycle 1+SETUP_CYC+STROBE_CYC+HOLD_CYC+TURN_CYC after the acceptance edge. This is 7 with the defaults. An error response arrives in cycle 1.
- Response data and pulse:
  - rsp_rdata = sampled data for a read, 0 for a write or an error.
  - rsp_rdata holds its value until the next response.
  - rsp_valid has no backpressure.
- Back-to-back: the next request can be accepted in the cycle after RESP (IDLE). Maximum throughput is one access per 1+SETUP+STROBE+HOLD+TURN+1 cycles.
- Idle pins: w_addr and w_data_o keep their last value when idle; w_data_oe is 0 outside SETUP/STROBE/HOLD of a write.
- Reset mid-access: all pins return to inactive on the reset edge, the FSM goes to IDLE, and no rsp_valid is produced for the aborted request.

Optional Feature:
- Macro: W5300_REG_ACCESS_STATS_EN.
- When defined, add three outputs, each 16 bits and saturating at 0xFFFF:
  - stat_rd_cnt: completed reads.
  - stat_wr_cnt: completed writes.
  - stat_err_cnt: error responses.
- Counters update in the RESP cycle and are cleared by rst.
- When not defined, these ports and their logic do not exist and behaviour is otherwise identical.

Test Plan:
- Common read, req_offset=0x0FE, w_data_i=0x5300 during strobe -> w_addr=0x0FE, w_rd_n low exactly 3 cycles; rsp_valid 7 cycles after acceptance with rsp_rdata=0x5300, rsp_err=0.
- Socket write, socket=3, offset=0x02, wdata=0x0001 -> w_addr=0x2C2, w_we_n low 3 cycles, w_data_oe=1 from SETUP through HOLD, w_data_o=0x0001; rsp_rdata=0.
- Invalid requests: socket=3 with SOCKET_NUM=2, or common offset=0x200 -> no w_cs_n activity, rsp_valid+rsp_err 1 cycle after acceptance.
- req_valid held high for 3 requests -> req_ready low during each access, accesses do not overlap, w_cs_n high for at least TURN_CYC between them.
- rst asserted in the 2nd STROBE cycle of a write -> next cycle all strobes/cs high, w_data_oe=0, req_ready=1, no rsp_valid.
- With the stats macro: 0xFFFF+2 reads -> stat_rd_cnt saturates at 0xFFFF, stat_wr_cnt=0.

Source files
------------

// File: rtl/w5300_reg_access.sv
// w5300_reg_access
//   Bus master for the W5300 direct-mode 16-bit host interface. It takes one
//   register read or write request at a time and runs it on the chip pins.
//   Each access has programmable setup, strobe, hold and turnaround timing.
//   Socket register addresses are derived from a socket index and an offset.
//
// Ports
//   clk, rst           : clock and synchronous active-high reset
//   req_*              : request handshake (valid/ready) and request fields
//   rsp_valid/err/rdata: one-cycle completion pulse, error flag and read data
//   w_cs_n/rd_n/we_n   : chip select and strobes (active low)
//   w_addr             : chip address
//   w_data_o/oe/i      : data pad output, output enable and input
//
// Optional build macro
//   W5300_REG_ACCESS_STATS_EN adds the outputs stat_rd_cnt, stat_wr_cnt and
//   stat_err_cnt. These are 16-bit saturating counters of completed reads,
//   completed writes and error responses.
module w5300_reg_access #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int SOCKET_NUM = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_common,
  input  logic [2:0]        req_socket,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              w_cs_n,
  output logic              w_rd_n,
  output logic              w_we_n,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data_o,
  output logic              w_data_oe,
  input  logic [DATA_W-1:0] w_data_i
`ifdef W5300_REG_ACCESS_STATS_EN
  ,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN, S_RESP
  } state_t;

  // Counter reload values: each phase lasts <N> cycles, so it counts N-1 .. 0.
  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TURN_LD   = 8'(TURN_CYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              accept;
  logic              req_err;
  logic [ADDR_W-1:0] addr_calc;
  logic              phase_done;

  assign accept     = req_valid && (state_q == S_IDLE);
  assign phase_done = (cnt_q == 8'd0);

  // Address decode. Socket windows are 0x40 apart starting at 0x200.
  // Accesses are 16-bit, so the byte-select bit is always cleared.
  always_comb begin
    req_err   = 1'b0;
    addr_calc = '0;
    if (req_common) begin
      addr_calc = req_offset;
      req_err   = (req_offset >= ADDR_W'(512));
    end else begin
      addr_calc = ADDR_W'(512) + (ADDR_W'(req_socket) << 6) + ADDR_W'(req_offset[5:0]);
      req_err   = ({29'd0, req_socket} >= 32'(SOCKET_NUM)) || (req_offset >= ADDR_W'(64));
    end
    addr_calc[0] = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter is reloaded on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = phase_done ? cnt_q : cnt_q - 8'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (req_valid) begin
          if (req_err) begin
            state_d = S_RESP;
          end else begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      S_SETUP:  if (phase_done) begin state_d = S_STROBE; cnt_d = STROBE_LD; end
      S_STROBE: if (phase_done) begin state_d = S_HOLD;   cnt_d = HOLD_LD;   end
      S_HOLD:   if (phase_done) begin state_d = S_TURN;   cnt_d = TURN_LD;   end
      S_TURN:   if (phase_done) begin state_d = S_RESP;   cnt_d = 8'd0;      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request capture and response data
  always_comb begin
    write_d  = write_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sample_d = sample_q;
    rdata_d  = rdata_q;
    if (accept) begin
      write_d = req_write;
      err_d   = req_err;
      // A rejected request leaves the pins untouched.
      if (!req_err) begin
        addr_d = addr_calc;
        if (req_write) wdata_d = req_wdata;
      end else begin
        rdata_d = '0;
      end
    end
    if (state_q == S_STROBE && phase_done && !write_q) sample_d = w_data_i;
    // rsp_rdata changes only when a response is about to be presented.
    if (state_q == S_TURN && phase_done) rdata_d = write_q ? '0 : sample_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sample_q <= '0;
      rdata_q  <= '0;
    end else begin
      write_q  <= write_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sample_q <= sample_d;
      rdata_q  <= rdata_d;
    end
  end

  // Output logic, decoded from the registered state
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_err   = (state_q == S_RESP) && err_q;
    rsp_rdata = rdata_q;
    w_addr    = addr_q;
    w_data_o  = wdata_q;
    w_cs_n    = !(state_q == S_SETUP || state_q == S_STROBE || state_q == S_HOLD);
    w_rd_n    = !(state_q == S_STROBE && !write_q);
    w_we_n    = !(state_q == S_STROBE && write_q);
    w_data_oe = write_q && !w_cs_n;
  end

`ifdef W5300_REG_ACCESS_STATS_EN
  logic [2:0]  stat_hit;
  logic [47:0] stat_vec;

  assign stat_hit[0] = (state_q == S_RESP) && !err_q && !write_q;
  assign stat_hit[1] = (state_q == S_RESP) && !err_q && write_q;
  assign stat_hit[2] = (state_q == S_RESP) && err_q;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] stat_q, stat_d;
      always_comb begin
        stat_d = stat_q;
        if (stat_hit[gi] && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
      end
      always_ff @(posedge clk) begin
        if (rst) stat_q <= 16'd0;
        else     stat_q <= stat_d;
      end
      assign stat_vec[gi*16 +: 16] = stat_q;
    end
  endgenerate

  assign stat_rd_cnt  = stat_vec[15:0];
  assign stat_wr_cnt  = stat_vec[31:16];
  assign stat_err_cnt = stat_vec[47:32];
`endif

endmodule

// File: tb/tb_w5300_reg_access.sv
module tb_w5300_reg_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_b = 1'b0;
  logic        req_write = 1'b0;
  logic        req_common = 1'b0;
  logic [2:0]  req_socket = 3'd0;
  logic [9:0]  req_offset = 10'd0;
  logic [15:0] req_wdata = 16'd0;
  logic [15:0] w_data_i = 16'hDEAD;

  logic        req_ready, rsp_valid, rsp_err, w_cs_n, w_rd_n, w_we_n, w_data_oe;
  logic [15:0] rsp_rdata, w_data_o;
  logic [9:0]  w_addr;

  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_cs_n, b_rd_n, b_we_n, b_data_oe;
  logic [15:0] b_rsp_rdata, b_data_o;
  logic [9:0]  b_addr;

  always #5 clk = ~clk;

  w5300_reg_access u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_common(req_common), .req_socket(req_socket), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .w_cs_n(w_cs_n), .w_rd_n(w_rd_n), .w_we_n(w_we_n), .w_addr(w_addr),
    .w_data_o(w_data_o), .w_data_oe(w_data_oe), .w_data_i(w_data_i)
  );

  // Second instance with only two sockets, used for the socket range check.
  w5300_reg_access #(.SOCKET_NUM(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(b_req_ready), .req_write(req_write),
    .req_common(req_common), .req_socket(req_socket), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
    .w_cs_n(b_cs_n), .w_rd_n(b_rd_n), .w_we_n(b_we_n), .w_addr(b_addr),
    .w_data_o(b_data_o), .w_data_oe(b_data_oe), .w_data_i(w_data_i)
  );

  typedef struct {
    logic        wr;
    logic        com;
    logic [2:0]  sock;
    logic [9:0]  off;
    logic [15:0] wdata;
    logic [15:0] din;
    logic [9:0]  exp_addr;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat = -1;
    int pulses = 0;
    int cs_cnt = 0, rd_cnt = 0, we_cnt = 0, oe_cnt = 0;
    int addr_bad = 0, data_bad = 0;
    logic        err_seen = 1'b0;
    logic [15:0] rdata_seen = 16'h0;
    int exp_lat;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
    req_write  = v.wr;
    req_common = v.com;
    req_socket = v.sock;
    req_offset = v.off;
    req_wdata  = v.wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    // Scramble the fields: they must have been captured at acceptance.
    req_offset = ~v.off;
    req_wdata  = ~v.wdata;
    req_socket = ~v.sock;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        pulses++;
        lat        = c;
        err_seen   = rsp_err;
        rdata_seen = rsp_rdata;
      end
      if (!w_cs_n) begin
        cs_cnt++;
        if (w_addr !== v.exp_addr) addr_bad++;
      end
      if (!w_rd_n) rd_cnt++;
      if (!w_we_n) we_cnt++;
      if (w_data_oe) begin
        oe_cnt++;
        if (w_data_o !== v.wdata) data_bad++;
      end
      // Valid read data only in the final (third) strobe cycle.
      w_data_i = (!w_rd_n && rd_cnt == 3) ? v.din : 16'hDEAD;
      if (c == 12) check($sformatf("v%0d_rdata_hold", idx), 32'(rsp_rdata), 32'(v.exp_rdata));
    end
    w_data_i = 16'hDEAD;
    exp_lat = v.exp_err ? 1 : 7;
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(exp_lat));
    check($sformatf("v%0d_pulses", idx), 32'(pulses), 32'd1);
    check($sformatf("v%0d_err", idx), 32'(err_seen), 32'(v.exp_err));
    check($sformatf("v%0d_rdata", idx), 32'(rdata_seen), 32'(v.exp_rdata));
    check($sformatf("v%0d_cs_cycles", idx), 32'(cs_cnt), v.exp_err ? 32'd0 : 32'd5);
    check($sformatf("v%0d_rd_cycles", idx), 32'(rd_cnt), (!v.wr && !v.exp_err) ? 32'd3 : 32'd0);
    check($sformatf("v%0d_we_cycles", idx), 32'(we_cnt), (v.wr && !v.exp_err) ? 32'd3 : 32'd0);
    check($sformatf("v%0d_oe_cycles", idx), 32'(oe_cnt), (v.wr && !v.exp_err) ? 32'd5 : 32'd0);
    check($sformatf("v%0d_addr_bad", idx), 32'(addr_bad), 32'd0);
    check($sformatf("v%0d_wdata_bad", idx), 32'(data_bad), 32'd0);
    $display("txn %0d wr=%0b com=%0b sock=%0d off=0x%03h addr=0x%03h lat=%0d err=%0b rdata=0x%04h",
             idx, v.wr, v.com, v.sock, v.off, v.exp_addr, lat, err_seen, rdata_seen);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //            wr    com   sock  off      wdata     din       addr     err   rdata
    vecs[0] = '{1'b0, 1'b1, 3'd0, 10'h0FE, 16'h0000, 16'h5300, 10'h0FE, 1'b0, 16'h5300};
    vecs[1] = '{1'b1, 1'b0, 3'd3, 10'h002, 16'h0001, 16'h0000, 10'h2C2, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 3'd0, 10'h101, 16'h0000, 16'hA5A5, 10'h100, 1'b0, 16'hA5A5};
    vecs[3] = '{1'b0, 1'b0, 3'd7, 10'h03F, 16'h0000, 16'h1234, 10'h3FE, 1'b0, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 3'd0, 10'h200, 16'hCAFE, 16'h0000, 10'h000, 1'b1, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 3'd0, 10'h040, 16'h0000, 16'h4444, 10'h000, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 3'd0, 10'h1FE, 16'hBEEF, 16'h0000, 10'h1FE, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 1'b0, 3'd1, 10'h010, 16'h0000, 16'hFFFF, 10'h250, 1'b0, 16'hFFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_cs_n", 32'(w_cs_n), 32'd1);
    check("rst_rd_n", 32'(w_rd_n), 32'd1);
    check("rst_we_n", 32'(w_we_n), 32'd1);
    check("rst_addr", 32'(w_addr), 32'd0);
    check("rst_data_o", 32'(w_data_o), 32'd0);
    check("rst_data_oe", 32'(w_data_oe), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Socket 3 on the two-socket instance is rejected with no bus activity.
    begin
      int lat = -1, pulses = 0, cs_cnt = 0;
      logic err_seen = 1'b0;
      logic [15:0] rd_seen = 16'h0;
      @(negedge clk);
      req_write = 1'b0; req_common = 1'b0; req_socket = 3'd3; req_offset = 10'h000;
      req_valid_b = 1'b1;
      @(posedge clk);
      #1 req_valid_b = 1'b0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (b_rsp_valid) begin pulses++; lat = c; err_seen = b_rsp_err; rd_seen = b_rsp_rdata; end
        if (!b_cs_n) cs_cnt++;
      end
      check("sock_range_latency", 32'(lat), 32'd1);
      check("sock_range_pulses", 32'(pulses), 32'd1);
      check("sock_range_err", 32'(err_seen), 32'd1);
      check("sock_range_rdata", 32'(rd_seen), 32'd0);
      check("sock_range_cs", 32'(cs_cnt), 32'd0);
      $display("txn sock_range sock=3 SOCKET_NUM=2 lat=%0d err=%0b", lat, err_seen);
    end

    // Back-to-back: req_valid held high for three requests.
    begin
      int accepts = 0, n_rsp = 0, viol = 0;
      int rsp_at [3];
      int gap_len = 0, min_gap = 999;
      logic seen_low = 1'b0;
      rsp_at[0] = -1; rsp_at[1] = -1; rsp_at[2] = -1;
      @(negedge clk);
      req_write = 1'b0; req_common = 1'b1; req_offset = 10'h010;
      req_valid = 1'b1;
      for (int c = 0; c <= 30; c++) begin
        if (c > 0) @(negedge clk);
        if (rsp_valid) begin
          if (n_rsp < 3) rsp_at[n_rsp] = c;
          n_rsp++;
        end
        if (!w_cs_n && req_ready) viol++;
        if (w_cs_n) begin
          if (seen_low) gap_len++;
        end else begin
          if (seen_low && gap_len > 0 && gap_len < min_gap) min_gap = gap_len;
          gap_len  = 0;
          seen_low = 1'b1;
        end
        if (req_valid && req_ready) begin
          accepts++;
          if (accepts == 3) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
          end
        end
      end
      check("b2b_accepts", 32'(accepts), 32'd3);
      check("b2b_rsp_count", 32'(n_rsp), 32'd3);
      check("b2b_rsp0_cycle", 32'(rsp_at[0]), 32'd7);
      check("b2b_rsp1_cycle", 32'(rsp_at[1]), 32'd15);
      check("b2b_rsp2_cycle", 32'(rsp_at[2]), 32'd23);
      check("b2b_ready_during_cs", 32'(viol), 32'd0);
      // CS high across TURN, RESP and IDLE between accesses.
      check("b2b_cs_gap", 32'(min_gap), 32'd3);
      $display("txn b2b accepts=%0d rsp_at=%0d,%0d,%0d min_gap=%0d",
               accepts, rsp_at[0], rsp_at[1], rsp_at[2], min_gap);
    end

    // Reset during the second strobe cycle of a write.
    begin
      int pulses = 0;
      @(negedge clk);
      req_write = 1'b1; req_common = 1'b1; req_offset = 10'h020; req_wdata = 16'h7777;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);                 // SETUP
      @(negedge clk);                 // STROBE 1
      @(negedge clk);                 // STROBE 2
      check("mid_rst_we_before", 32'(w_we_n), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_cs_n", 32'(w_cs_n), 32'd1);
      check("mid_rst_we_n", 32'(w_we_n), 32'd1);
      check("mid_rst_rd_n", 32'(w_rd_n), 32'd1);
      check("mid_rst_oe", 32'(w_data_oe), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd1);
      for (int c = 0; c < 10; c++) begin
        if (rsp_valid) pulses++;
        @(negedge clk);
      end
      check("mid_rst_no_rsp", 32'(pulses), 32'd0);
      $display("txn mid_reset write aborted rsp_pulses=%0d", pulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
